// File: rtl/run_sequencer_pkg.sv
// Shared state encoding for the batch run controller.
package run_sequencer_pkg;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_INIT,
        RS_RUN,
        RS_RESULT,
        RS_FINISH
    } run_state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// Loadable up/down cycle counter with clear, enable and a terminal-count compare.
module run_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [CNT_W-1:0] tc_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge CLK) begin
        if (reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    assign tc = (count == tc_val);

endmodule

// File: rtl/run_sequencer.sv
// Batch run controller: holds the datapath in init, runs each program until
// DONE or timeout, and reports per-program cycle counts.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int MAX_CYCLES  = 50000,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             go,
    input  logic [1:0]       num_progs,
    input  logic             DONE,
    output logic             START,
    output logic [1:0]       prog_idx,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_cycles,
    output logic             result_timeout,
    output logic             batch_done
);

    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_VAL   = CNT_W'(MAX_CYCLES);

    run_state_t       state;
    logic [1:0]       num_latched;
    logic             last_prog;
    logic             go_accept;
    logic             init_load;
    logic             init_en;
    logic             init_last;
    logic             run_clr;
    logic             run_en;
    logic             run_last;
    logic [CNT_W-1:0] run_count;
    logic [CNT_W-1:0] init_count_unused;

    assign go_accept = (state == RS_IDLE) && go && (num_progs != 2'd0);
    assign last_prog = (prog_idx == num_latched - 2'd1);

    always_comb begin
        init_load = go_accept || ((state == RS_RESULT) && !last_prog);
        init_en   = (state == RS_INIT);
        run_clr   = (state == RS_INIT) && init_last;
        run_en    = (state == RS_RUN);
    end

    // Counts down from INIT_CYCLES-1; reaching zero marks the last init cycle.
    run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_init_cnt (
        .CLK      (CLK),
        .reset    (reset),
        .clr      (1'b0),
        .load     (init_load),
        .load_val (INIT_LOAD),
        .en       (init_en),
        .up       (1'b0),
        .tc_val   ('0),
        .count    (init_count_unused),
        .tc       (init_last)
    );

    // run_last flags the RUN cycle whose increment reaches MAX_CYCLES.
    run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .CLK      (CLK),
        .reset    (reset),
        .clr      (run_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (run_en),
        .up       (1'b1),
        .tc_val   (RUN_LAST),
        .count    (run_count),
        .tc       (run_last)
    );

    assign cycle_count = run_count;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= RS_IDLE;
            START          <= 1'b1;
            busy           <= 1'b0;
            prog_idx       <= 2'd0;
            num_latched    <= 2'd0;
            result_valid   <= 1'b0;
            result_cycles  <= '0;
            result_timeout <= 1'b0;
            batch_done     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            batch_done   <= 1'b0;
            case (state)
                RS_IDLE: begin
                    if (go_accept) begin
                        num_latched <= num_progs;
                        prog_idx    <= 2'd0;
                        busy        <= 1'b1;
                        state       <= RS_INIT;
                    end
                end
                RS_INIT: begin
                    if (init_last) begin
                        START <= 1'b0;
                        state <= RS_RUN;
                    end
                end
                RS_RUN: begin
                    // DONE takes priority over a coincident timeout.
                    if (DONE) begin
                        result_cycles  <= run_count + 1'b1;
                        result_timeout <= 1'b0;
                        result_valid   <= 1'b1;
                        START          <= 1'b1;
                        state          <= RS_RESULT;
                    end else if (run_last) begin
                        result_cycles  <= MAX_VAL;
                        result_timeout <= 1'b1;
                        result_valid   <= 1'b1;
                        START          <= 1'b1;
                        state          <= RS_RESULT;
                    end
                end
                RS_RESULT: begin
                    if (last_prog) begin
                        batch_done <= 1'b1;
                        state      <= RS_FINISH;
                    end else begin
                        prog_idx <= prog_idx + 2'd1;
                        state    <= RS_INIT;
                    end
                end
                RS_FINISH: begin
                    busy  <= 1'b0;
                    state <= RS_IDLE;
                end
                default: begin
                    state <= RS_IDLE;
                end
            endcase
        end
    end

endmodule
